// File: rtl/uart_rx_fifo.sv
// UART receiver with 16x oversampling, 2-of-3 majority bit decisions, optional even
// parity and a first-word-fall-through receive FIFO with overrun detection.
module uart_rx_fifo #(
    parameter int N     = 8,
    parameter int DIV   = 10,
    parameter int DEPTH = 8
) (
    input  logic                     sysclk,
    input  logic                     reset,
    input  logic                     parity_i,
    input  logic                     rx_i,
    input  logic                     rd_ready_i,
    output logic                     rd_valid_o,
    output logic [N-1:0]             rd_data_o,
    output logic [$clog2(DEPTH):0]   fifo_count_o,
    output logic                     busy_o,
    output logic                     frame_err_o,
    output logic                     parity_err_o,
    output logic                     overrun_o
);

    localparam int DW = $clog2(DIV);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    function automatic logic calc_parity(input logic [N-1:0] d);
        return ^d;
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic            rx_meta_r, rx_sync_r, rx_prev_r;
    logic [DW-1:0]   div_cnt_r;
    logic [3:0]      tick_idx_r;
    logic            samp7_r, samp8_r;
    state_t          state_r, state_nx_s;
    logic            par_en_r, par_err_r;
    logic [N-1:0]    shift_r;
    logic [3:0]      bit_cnt_r;
    logic            busy_r, frame_err_r, parity_err_r, overrun_r;
    logic            push_r;
    logic [N-1:0]    push_data_r;

    logic            tick_s, fall_s, decide_s, bit_end_s, bit_s;
    logic            shift_en_s, par_chk_s, frame_bad_s, parity_bad_s, good_s;

    logic [N-1:0]    mem_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r, rd_ptr_r, rd_ptr_nx_s;
    logic [CW-1:0]   count_r, count_nx_s;
    logic            rd_valid_r;
    logic [N-1:0]    rd_data_r, head_nx_s;
    logic            full_s, do_pop_s, do_push_s, ovr_s;

    assign tick_s    = (div_cnt_r == DW'(DIV - 1));
    assign fall_s    = (state_r == IDLE) && rx_prev_r && !rx_sync_r;
    assign decide_s  = tick_s && (tick_idx_r == 4'd9);
    assign bit_end_s = tick_s && (tick_idx_r == 4'd15);
    assign bit_s     = maj3(samp7_r, samp8_r, rx_sync_r);

    // Two-flop synchronizer plus previous value for falling-edge detection.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= rx_i;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // Oversample tick divider and tick index; realigned to every start edge.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            div_cnt_r  <= '0;
            tick_idx_r <= 4'd0;
        end else if (fall_s) begin
            div_cnt_r  <= '0;
            tick_idx_r <= 4'd0;
        end else if (tick_s) begin
            div_cnt_r  <= '0;
            tick_idx_r <= tick_idx_r + 4'd1;
        end else begin
            div_cnt_r  <= div_cnt_r + DW'(1);
        end
    end

    // Receive FSM next-state and one-cycle control strobes.
    always_comb begin
        state_nx_s   = state_r;
        shift_en_s   = 1'b0;
        par_chk_s    = 1'b0;
        frame_bad_s  = 1'b0;
        parity_bad_s = 1'b0;
        good_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (fall_s) state_nx_s = START;
                else        state_nx_s = IDLE;
            end
            START: begin
                if (decide_s && bit_s) state_nx_s = IDLE;
                else if (bit_end_s)    state_nx_s = DATA;
                else                   state_nx_s = START;
            end
            DATA: begin
                shift_en_s = decide_s;
                if (bit_end_s && (bit_cnt_r == 4'(N))) state_nx_s = par_en_r ? PARITY : STOP;
                else                                   state_nx_s = DATA;
            end
            PARITY: begin
                par_chk_s = decide_s;
                if (bit_end_s) state_nx_s = STOP;
                else           state_nx_s = PARITY;
            end
            STOP: begin
                if (decide_s) begin
                    state_nx_s   = IDLE;
                    frame_bad_s  = !bit_s;
                    parity_bad_s = bit_s && par_err_r;
                    good_s       = bit_s && !par_err_r;
                end else begin
                    state_nx_s = STOP;
                end
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // FSM state, busy flag and registered result pulses.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_r      <= IDLE;
            busy_r       <= 1'b0;
            frame_err_r  <= 1'b0;
            parity_err_r <= 1'b0;
            push_r       <= 1'b0;
            push_data_r  <= '0;
        end else begin
            state_r      <= state_nx_s;
            busy_r       <= (state_nx_s != IDLE);
            frame_err_r  <= frame_bad_s;
            parity_err_r <= parity_bad_s;
            push_r       <= good_s;
            if (good_s) push_data_r <= shift_r;
        end
    end

    // Bit samples, data shift register and per-frame parity tracking.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            samp7_r   <= 1'b1;
            samp8_r   <= 1'b1;
            shift_r   <= '0;
            bit_cnt_r <= 4'd0;
            par_en_r  <= 1'b0;
            par_err_r <= 1'b0;
        end else begin
            if (tick_s && (tick_idx_r == 4'd7)) samp7_r <= rx_sync_r;
            if (tick_s && (tick_idx_r == 4'd8)) samp8_r <= rx_sync_r;
            if (fall_s) begin
                bit_cnt_r <= 4'd0;
                par_en_r  <= parity_i;
                par_err_r <= 1'b0;
            end else if (shift_en_s) begin
                shift_r   <= {bit_s, shift_r[N-1:1]};
                bit_cnt_r <= bit_cnt_r + 4'd1;
            end else if (par_chk_s) begin
                par_err_r <= calc_parity(shift_r) ^ bit_s;
            end
        end
    end

    assign full_s    = (count_r == CW'(DEPTH));
    assign do_pop_s  = rd_valid_r && rd_ready_i;
    assign do_push_s = push_r && (!full_s || do_pop_s);
    assign ovr_s     = push_r && full_s && !do_pop_s;

    // Next FIFO occupancy, read pointer and head word (head register stays fall-through).
    always_comb begin
        count_nx_s  = count_r;
        rd_ptr_nx_s = rd_ptr_r;
        head_nx_s   = '0;
        if (do_push_s && !do_pop_s)      count_nx_s = count_r + CW'(1);
        else if (do_pop_s && !do_push_s) count_nx_s = count_r - CW'(1);
        else                             count_nx_s = count_r;
        if (do_pop_s) rd_ptr_nx_s = rd_ptr_r + AW'(1);
        else          rd_ptr_nx_s = rd_ptr_r;
        if (count_nx_s == CW'(0))                       head_nx_s = '0;
        else if (do_push_s && (rd_ptr_nx_s == wr_ptr_r)) head_nx_s = push_data_r;
        else                                            head_nx_s = mem_r[rd_ptr_nx_s];
    end

    // FIFO storage.
    always_ff @(posedge sysclk) begin
        if (do_push_s) mem_r[wr_ptr_r] <= push_data_r;
    end

    // FIFO pointers, count and registered read-side outputs.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            rd_valid_r <= 1'b0;
            rd_data_r  <= '0;
            overrun_r  <= 1'b0;
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            rd_ptr_r   <= rd_ptr_nx_s;
            count_r    <= count_nx_s;
            rd_valid_r <= (count_nx_s != CW'(0));
            rd_data_r  <= head_nx_s;
            overrun_r  <= ovr_s;
        end
    end

    assign rd_valid_o   = rd_valid_r;
    assign rd_data_o    = rd_data_r;
    assign fifo_count_o = count_r;
    assign busy_o       = busy_r;
    assign frame_err_o  = frame_err_r;
    assign parity_err_o = parity_err_r;
    assign overrun_o    = overrun_r;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: serial frames are generated bit by bit, expected
// words are queued as frames are sent and checked as the FIFO pops them.
module tb_uart_rx_fifo;
    localparam int N = 8, DIV = 4, DEPTH = 8, BIT = 16 * DIV;

    logic sysclk = 1'b0, reset = 1'b1, parity_i = 1'b0, rx_i = 1'b1, rd_ready_i = 1'b0;
    logic rd_valid_o, busy_o, frame_err_o, parity_err_o, overrun_o;
    logic [N-1:0] rd_data_o;
    logic [$clog2(DEPTH):0] fifo_count_o;

    uart_rx_fifo #(.N(N), .DIV(DIV), .DEPTH(DEPTH)) dut (
        .sysclk(sysclk), .reset(reset), .parity_i(parity_i), .rx_i(rx_i),
        .rd_ready_i(rd_ready_i), .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o),
        .fifo_count_o(fifo_count_o), .busy_o(busy_o), .frame_err_o(frame_err_o),
        .parity_err_o(parity_err_o), .overrun_o(overrun_o)
    );

    always #5 sysclk = ~sysclk;

    int total = 0, bad = 0, cyc = 0;
    int pop_cnt = 0, last_pop_cyc = 0, ferr_cnt = 0, perr_cnt = 0, ovr_cnt = 0;
    logic [N-1:0] exp_q[$];

    always @(posedge sysclk) cyc <= cyc + 1;

    // Pulse counters and scoreboard check on every accepted read.
    always @(negedge sysclk) begin
        logic [N-1:0] exp_w;
        if (frame_err_o)  ferr_cnt++;
        if (parity_err_o) perr_cnt++;
        if (overrun_o)    ovr_cnt++;
        if (rd_valid_o && rd_ready_i) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL pop_unexpected got=%h required=none", rd_data_o);
            end else begin
                exp_w = exp_q.pop_front();
                if (rd_data_o !== exp_w) begin
                    bad++;
                    $display("FAIL pop_data got=%h required=%h", rd_data_o, exp_w);
                end
            end
            pop_cnt++;
            last_pop_cyc = cyc;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        rx_i = v;
        tick(BIT);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_en, input logic par_bit,
                              input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < N; i++) drive_bit(d[i]);
        if (par_en) drive_bit(par_bit);
        drive_bit(stop_bit);
        rx_i = 1'b1;
    endtask

    task automatic check_int(input string name, input int got, input int req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s got=%0d required=%0d", name, got, req);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick(5);
        check_int("reset_busy", int'(busy_o), 0);
        check_int("reset_valid", int'(rd_valid_o), 0);
        check_int("reset_count", int'(fifo_count_o), 0);
        check_int("reset_data", int'(rd_data_o), 0);
        check_int("reset_pulses", int'({frame_err_o, parity_err_o, overrun_o}), 0);
        reset = 1'b0;
        tick(BIT);
    endtask

    task automatic test_basic;
        logic [7:0] pats [4];
        int p0, e0, start;
        pats[0] = 8'h55; pats[1] = 8'h00; pats[2] = 8'hFF; pats[3] = 8'h81;
        rd_ready_i = 1'b1;
        parity_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            p0 = pop_cnt;
            e0 = ferr_cnt + perr_cnt + ovr_cnt;
            start = cyc;
            exp_q.push_back(pats[k]);
            send_frame(pats[k], 1'b0, 1'b0, 1'b1);
            tick(4);
            check_int("basic_pop", pop_cnt - p0, 1);
            check_int("basic_latency_ok", int'((last_pop_cyc - start) <= 10 * BIT), 1);
            check_int("basic_no_err", ferr_cnt + perr_cnt + ovr_cnt - e0, 0);
        end
    endtask

    task automatic test_parity;
        int p0, q0;
        rd_ready_i = 1'b1;
        parity_i = 1'b1;
        p0 = pop_cnt; q0 = perr_cnt;
        exp_q.push_back(8'hA3);
        send_frame(8'hA3, 1'b1, 1'b0, 1'b1);
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1, 1'b1, 1'b1);
        tick(4);
        check_int("parity_good_pop", pop_cnt - p0, 2);
        check_int("parity_good_noerr", perr_cnt - q0, 0);
        p0 = pop_cnt;
        send_frame(8'hA3, 1'b1, 1'b1, 1'b1);
        tick(4);
        check_int("parity_bad_pulse", perr_cnt - q0, 1);
        check_int("parity_bad_count", int'(fifo_count_o), 0);
        check_int("parity_bad_nopop", pop_cnt - p0, 0);
        parity_i = 1'b0;
    endtask

    task automatic test_frame_err;
        int p0, f0, q0;
        rd_ready_i = 1'b1;
        p0 = pop_cnt; f0 = ferr_cnt; q0 = perr_cnt;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        tick(2 * BIT);
        check_int("frame_err_pulse", ferr_cnt - f0, 1);
        check_int("frame_err_nopop", pop_cnt - p0, 0);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
        tick(4);
        check_int("frame_err_recover", pop_cnt - p0, 1);
        parity_i = 1'b1;
        send_frame(8'hA3, 1'b1, 1'b1, 1'b0);
        parity_i = 1'b0;
        tick(2 * BIT);
        check_int("frame_err_precedence_f", ferr_cnt - f0, 2);
        check_int("frame_err_precedence_p", perr_cnt - q0, 0);
    endtask

    task automatic test_glitch;
        int p0, e0;
        p0 = pop_cnt; e0 = ferr_cnt + perr_cnt + ovr_cnt;
        rx_i = 1'b0;
        tick(3 * DIV);
        rx_i = 1'b1;
        tick(8);
        check_int("glitch_busy_high", int'(busy_o), 1);
        tick(40);
        check_int("glitch_busy_low", int'(busy_o), 0);
        tick(BIT);
        check_int("glitch_nopop", pop_cnt - p0, 0);
        check_int("glitch_noerr", ferr_cnt + perr_cnt + ovr_cnt - e0, 0);
    endtask

    task automatic test_back_to_back;
        int p0, o0;
        rd_ready_i = 1'b0;
        p0 = pop_cnt; o0 = ovr_cnt;
        for (int k = 1; k <= 9; k++) begin
            if (k <= DEPTH) exp_q.push_back(8'(k));
            send_frame(8'(k), 1'b0, 1'b0, 1'b1);
        end
        tick(4);
        check_int("b2b_count_full", int'(fifo_count_o), DEPTH);
        check_int("b2b_overrun", ovr_cnt - o0, 1);
        check_int("b2b_head", int'(rd_data_o), 1);
        rd_ready_i = 1'b1;
        tick(12);
        check_int("b2b_drained", pop_cnt - p0, DEPTH);
        check_int("b2b_valid_low", int'(rd_valid_o), 0);
        tick(4);
        check_int("b2b_empty_ready", int'(fifo_count_o), 0);
    endtask

    task automatic test_reset_mid_frame;
        int p0, e0;
        rd_ready_i = 1'b0;
        e0 = ferr_cnt + perr_cnt + ovr_cnt;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        rx_i = 1'b1;
        tick(BIT / 2);
        check_int("mid_busy_before", int'(busy_o), 1);
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(1);
        check_int("mid_busy_after", int'(busy_o), 0);
        tick(2 * BIT);
        check_int("mid_count_zero", int'(fifo_count_o), 0);
        exp_q.push_back(8'h12);
        send_frame(8'h12, 1'b0, 1'b0, 1'b1);
        tick(4);
        check_int("mid_count_one", int'(fifo_count_o), 1);
        check_int("mid_head", int'(rd_data_o), 8'h12);
        check_int("mid_noerr", ferr_cnt + perr_cnt + ovr_cnt - e0, 0);
        p0 = pop_cnt;
        rd_ready_i = 1'b1;
        tick(4);
        check_int("mid_pop", pop_cnt - p0, 1);
    endtask

    initial begin
        tick(1);
        test_reset;
        test_basic;
        test_parity;
        test_frame_err;
        test_glitch;
        test_back_to_back;
        test_reset_mid_frame;
        check_int("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter N, default 8: data bits per frame (5..9).
REQ-002 SHALL have parameter DIV, default 10: sysclk cycles per oversample tick (>=2).
REQ-003 SHALL have parameter DEPTH, default 8: receive FIFO entries (power of 2, >=2).
REQ-004 SHALL have port sysclk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port parity_i  in  1  1 = even parity bit expected after data; 0 = none.
REQ-007 SHALL have port rx_i  in  1  asynchronous serial line, idle high.
REQ-008 SHALL have port rd_ready_i  in  1  consumer accepts head word.
REQ-009 SHALL have port rd_valid_o  out  1  FIFO non-empty.
REQ-010 SHALL have port rd_data_o  out  N  FIFO head word (first-word-fall-through).
REQ-011 SHALL have port fifo_count_o  out  $clog2(DEPTH)+1  entries held.
REQ-012 SHALL have port busy_o  out  1  frame in progress (state != IDLE).
REQ-013 SHALL have port frame_err_o, parity_err_o, overrun_o  out  1 each  one-cycle error pulses.

Function
REQ-014 rx_i SHALL pass a 2-FF synchronizer (flops reset to 1); all decoding uses the synchronized value.
REQ-015 Tick generator SHALL assert one-cycle tick every DIV sysclk cycles; bit period = 16 ticks = 16*DIV cycles.
REQ-016 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; reset state IDLE.
REQ-017 IDLE: on synchronized 1->0 transition SHALL clear tick divider and tick index (0..15), latch parity_i for the frame, go START.
REQ-018 Each bit SHALL be decided by 2-of-3 majority of samples at tick indices 7, 8, 9; decision taken at index 9.
REQ-019 START: majority 1 (glitch) -> IDLE, nothing reported; majority 0 -> DATA at the bit boundary (after index 15).
REQ-020 DATA: N bits, LSB first, shifted into a holding register; then PARITY if latched parity set, else STOP.
REQ-021 PARITY: error flag set if XOR(data, parity bit) != 0; then STOP.
REQ-022 STOP: at decision point (index 9) SHALL return to IDLE immediately, without waiting for bit end, so back-to-back frames are received.
REQ-023 Stop majority 0 -> frame_err_o pulse, word discarded; takes precedence over parity error.
REQ-024 Stop 1 with parity error -> parity_err_o pulse, word discarded.
REQ-025 Good frame SHALL push to FIFO on the cycle after the stop decision; rd_valid_o visible the following cycle.
REQ-026 Push while full and no pop in that cycle -> overrun_o pulse, word dropped, FIFO unchanged.
REQ-027 Pop occurs when rd_valid_o && rd_ready_i; pop and push in same cycle SHALL both take effect (count unchanged, including when full).
REQ-028 FIFO pointers SHALL wrap modulo DEPTH; words SHALL emerge in arrival order.
REQ-029 rd_ready_i while empty SHALL have no effect.

Reset
REQ-030 Reset SHALL force: state IDLE, busy_o 0, rd_valid_o 0, fifo_count_o 0, rd_data_o 0, all error pulses 0, synchronizer 1, tick divider 0.
REQ-031 Reset asserted mid-frame SHALL abandon the frame with no push or error pulse; first falling edge after release starts a new frame.

Verification (DIV=4, N=8, DEPTH=8; bit = 64 cycles)
REQ-032 Frame 0x55, parity_i=0, rd_ready_i=1 -> rd_data_o=0x55 with rd_valid_o high within 10 bit times of start edge; no error pulses.
REQ-033 parity_i=1, 0xA3 with parity bit 0 -> 0xA3 pushed; same frame with parity bit 1 -> one parity_err_o pulse, fifo_count_o stays 0.
REQ-034 0x3C with stop bit driven 0 -> one frame_err_o pulse, no push; next valid 0x3C received correctly.
REQ-035 rx_i low for 3*DIV cycles then high -> busy_o returns 0 at the start decision, no push, no error pulses.
REQ-036 9 back-to-back frames 0x01..0x09, rd_ready_i=0 -> fifo_count_o=8, one overrun_o on 9th; draining yields 0x01..0x08 in order, then rd_valid_o=0.
REQ-037 Reset pulsed during DATA of frame 0x77, then frame 0x12 -> only 0x12 in FIFO, fifo_count_o=1.
